// File: rtl/mips_inst_issuer.sv
// Instruction issuer for the 6-register MIPS core: encodes requests, queues words, issues them under an outstanding limit.
// Optional build macro MIPS_ISSUE_GAP_EN forces an idle cycle after every issue.
module mips_inst_issuer #(
  parameter int FIFO_DEPTH      = 4,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_op,
  input  logic [2:0]  req_rs,
  input  logic [2:0]  req_rt,
  input  logic [2:0]  req_rd,
  input  logic [4:0]  req_shamt,
  input  logic [15:0] req_imm,
  output logic        in_valid,
  output logic [31:0] instruction,
  input  logic        out_valid,
  input  logic        instruction_fail,
  output logic [2:0]  outstanding,
  output logic [15:0] fail_cnt,
  output logic        err_unexpected
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  localparam logic [2:0] OP_ADD  = 3'd0;
  localparam logic [2:0] OP_AND  = 3'd1;
  localparam logic [2:0] OP_OR   = 3'd2;
  localparam logic [2:0] OP_NOR  = 3'd3;
  localparam logic [2:0] OP_SLL  = 3'd4;
  localparam logic [2:0] OP_SRL  = 3'd5;
  localparam logic [2:0] OP_ADDI = 3'd6;

  logic [31:0]   fifoMem_q [FIFO_DEPTH];
  logic [PW-1:0] wrPtr_q, wrPtr_d, rdPtr_q, rdPtr_d;
  logic [CW-1:0] count_q, count_d;
  logic          inValid_q, inValid_d;
  logic [31:0]   instr_q, instr_d;
  logic [2:0]    outstanding_q, outstanding_d;
  logic [15:0]   failCnt_q, failCnt_d;
  logic          err_q, err_d;
  logic [31:0]   encWord;
  logic          push, issue, respOk;

  // The core only decodes these six register addresses; 00000 is ignored.
  function automatic logic [4:0] mapReg(input logic [2:0] idx);
    case (idx)
      3'd0:    mapReg = 5'b10001;
      3'd1:    mapReg = 5'b10010;
      3'd2:    mapReg = 5'b01000;
      3'd3:    mapReg = 5'b10111;
      3'd4:    mapReg = 5'b11111;
      3'd5:    mapReg = 5'b10000;
      default: mapReg = 5'b00000;
    endcase
  endfunction

  always_comb begin
    encWord = 32'hFC000000;
    case (req_op)
      OP_ADD:  encWord = {6'b000000, mapReg(req_rs), mapReg(req_rt), mapReg(req_rd), 5'd0, 6'b100000};
      OP_AND:  encWord = {6'b000000, mapReg(req_rs), mapReg(req_rt), mapReg(req_rd), 5'd0, 6'b100100};
      OP_OR:   encWord = {6'b000000, mapReg(req_rs), mapReg(req_rt), mapReg(req_rd), 5'd0, 6'b100101};
      OP_NOR:  encWord = {6'b000000, mapReg(req_rs), mapReg(req_rt), mapReg(req_rd), 5'd0, 6'b100111};
      OP_SLL:  encWord = {6'b000000, 5'd0, mapReg(req_rt), mapReg(req_rd), req_shamt, 6'b000000};
      OP_SRL:  encWord = {6'b000000, 5'd0, mapReg(req_rt), mapReg(req_rd), req_shamt, 6'b000010};
      OP_ADDI: encWord = {6'b001000, mapReg(req_rs), mapReg(req_rd), req_imm};
      default: encWord = 32'hFC000000;
    endcase
  end

  assign req_ready = !rst && (count_q != CW'(FIFO_DEPTH));
  assign push      = req_valid && req_ready;
  assign respOk    = out_valid && (outstanding_q != 3'd0);

`ifdef MIPS_ISSUE_GAP_EN
  assign issue = (count_q != '0) && (outstanding_q < 3'(MAX_OUTSTANDING)) && !inValid_q;
`else
  assign issue = (count_q != '0) && (outstanding_q < 3'(MAX_OUTSTANDING));
`endif

  always_comb begin
    wrPtr_d       = push  ? wrPtr_q + PW'(1) : wrPtr_q;
    rdPtr_d       = issue ? rdPtr_q + PW'(1) : rdPtr_q;
    count_d       = count_q;
    outstanding_d = outstanding_q;
    case ({push, issue})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    // A response with nothing outstanding is flagged but never cancels a real issue.
    case ({issue, respOk})
      2'b10:   outstanding_d = outstanding_q + 3'd1;
      2'b01:   outstanding_d = outstanding_q - 3'd1;
      default: outstanding_d = outstanding_q;
    endcase
    inValid_d = issue;
    instr_d   = issue ? fifoMem_q[rdPtr_q] : 32'd0;
    err_d     = err_q || (out_valid && (outstanding_q == 3'd0));
    failCnt_d = (out_valid && instruction_fail && (failCnt_q != 16'hFFFF)) ? failCnt_q + 16'd1 : failCnt_q;
  end

  always_ff @(posedge clk) begin
    if (push) fifoMem_q[wrPtr_q] <= encWord;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wrPtr_q       <= '0;
      rdPtr_q       <= '0;
      count_q       <= '0;
      inValid_q     <= 1'b0;
      instr_q       <= 32'd0;
      outstanding_q <= 3'd0;
      failCnt_q     <= 16'd0;
      err_q         <= 1'b0;
    end else begin
      wrPtr_q       <= wrPtr_d;
      rdPtr_q       <= rdPtr_d;
      count_q       <= count_d;
      inValid_q     <= inValid_d;
      instr_q       <= instr_d;
      outstanding_q <= outstanding_d;
      failCnt_q     <= failCnt_d;
      err_q         <= err_d;
    end
  end

  assign in_valid       = inValid_q;
  assign instruction    = instr_q;
  assign outstanding    = outstanding_q;
  assign fail_cnt       = failCnt_q;
  assign err_unexpected = err_q;

endmodule

// File: tb/tb_mips_inst_issuer.sv
// Testbench for mips_inst_issuer: fixed encoding vectors, hand-written corner sequences and a randomized run against a queue model.
module tb_mips_inst_issuer;

  localparam int FIFO_DEPTH = 4;
  localparam int MAX_OUT    = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [2:0]  req_op = '0, req_rs = '0, req_rt = '0, req_rd = '0;
  logic [4:0]  req_shamt = '0;
  logic [15:0] req_imm = '0;
  logic        in_valid;
  logic [31:0] instruction;
  logic        out_valid = 1'b0, instruction_fail = 1'b0;
  logic [2:0]  outstanding;
  logic [15:0] fail_cnt;
  logic        err_unexpected;

  always #5 clk = ~clk;

  mips_inst_issuer #(.FIFO_DEPTH(FIFO_DEPTH), .MAX_OUTSTANDING(MAX_OUT)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_rs(req_rs), .req_rt(req_rt), .req_rd(req_rd),
    .req_shamt(req_shamt), .req_imm(req_imm), .in_valid(in_valid),
    .instruction(instruction), .out_valid(out_valid),
    .instruction_fail(instruction_fail), .outstanding(outstanding),
    .fail_cnt(fail_cnt), .err_unexpected(err_unexpected)
  );

  int testsRun = 0;
  int testsFailed = 0;

  // Reference model: a queue of pending words plus plain counters.
  logic [31:0] modelQ[$];
  int          mOut = 0;
  int          mFail = 0;
  bit          mErr = 1'b0;
  bit          mInValid = 1'b0;
  logic [31:0] mInstr = 32'd0;
  int          regMap[8] = '{17, 18, 8, 23, 31, 16, 0, 0};

  typedef struct {
    logic [2:0]  op, rs, rt, rd;
    logic [4:0]  sh;
    logic [15:0] imm;
    logic [31:0] expWord;
  } vec_t;
  vec_t vecs[8];

  function automatic logic [31:0] encodeRef(input logic [2:0] op, rs, rt, rd,
                                            input logic [4:0] sh, input logic [15:0] imm);
    int w;
    int functs[4] = '{32, 36, 37, 39};
    case (op)
      3'd0, 3'd1, 3'd2, 3'd3:
        w = regMap[rs] * (1 << 21) + regMap[rt] * (1 << 16) + regMap[rd] * (1 << 11) + functs[op[1:0]];
      3'd4, 3'd5:
        w = regMap[rt] * (1 << 16) + regMap[rd] * (1 << 11) + int'(sh) * 64 + ((op == 3'd5) ? 2 : 0);
      3'd6:
        w = 8 * (1 << 26) + regMap[rs] * (1 << 21) + regMap[rd] * (1 << 16) + int'(imm);
      default:
        w = 32'hFC000000;
    endcase
    return 32'(w);
  endfunction

  task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checkOutput();
    checkVal("in_valid",       32'(in_valid),       32'(mInValid));
    checkVal("instruction",    instruction,         mInstr);
    checkVal("outstanding",    32'(outstanding),    32'(mOut));
    checkVal("fail_cnt",       32'(fail_cnt),       32'(mFail));
    checkVal("err_unexpected", 32'(err_unexpected), 32'(mErr));
  endtask

  // Drives one cycle of inputs, checks readiness, advances the model, then checks the registered outputs.
  task automatic applyStimulus(input bit rstV, input bit vld, input logic [2:0] op, rs, rt, rd,
                               input logic [4:0] sh, input logic [15:0] imm,
                               input bit ov, input bit fl);
    bit expReady, doPush, doIssue, gapBlock;
    rst = rstV; req_valid = vld; req_op = op; req_rs = rs; req_rt = rt; req_rd = rd;
    req_shamt = sh; req_imm = imm; out_valid = ov; instruction_fail = fl;
    #1;
    expReady = !rstV && (modelQ.size() < FIFO_DEPTH);
    checkVal("req_ready", 32'(req_ready), 32'(expReady));
    if (rstV) begin
      modelQ.delete();
      mOut = 0; mFail = 0; mErr = 1'b0; mInValid = 1'b0; mInstr = 32'd0;
    end else begin
`ifdef MIPS_ISSUE_GAP_EN
      gapBlock = mInValid;
`else
      gapBlock = 1'b0;
`endif
      doPush  = vld && expReady;
      doIssue = (modelQ.size() > 0) && (mOut < MAX_OUT) && !gapBlock;
      if (ov) begin
        if (mOut == 0) mErr = 1'b1;
        else mOut--;
        if (fl && mFail < 65535) mFail++;
      end
      if (doIssue) begin
        mInstr = modelQ.pop_front();
        mInValid = 1'b1;
        mOut++;
      end else begin
        mInstr = 32'd0;
        mInValid = 1'b0;
      end
      if (doPush) modelQ.push_back(encodeRef(op, rs, rt, rd, sh, imm));
    end
    @(posedge clk);
    #1;
    checkOutput();
  endtask

  task automatic idleCycle();
    applyStimulus(1'b0, 1'b0, 3'd0, 3'd0, 3'd0, 3'd0, 5'd0, 16'd0, 1'b0, 1'b0);
  endtask

  task automatic resetCycle();
    applyStimulus(1'b1, 1'b0, 3'd0, 3'd0, 3'd0, 3'd0, 5'd0, 16'd0, 1'b0, 1'b0);
  endtask

  task automatic pushReq(input logic [2:0] op, rs, rt, rd, input logic [4:0] sh, input logic [15:0] imm);
    applyStimulus(1'b0, 1'b1, op, rs, rt, rd, sh, imm, 1'b0, 1'b0);
  endtask

  task automatic respond(input bit fl);
    applyStimulus(1'b0, 1'b0, 3'd0, 3'd0, 3'd0, 3'd0, 5'd0, 16'd0, 1'b1, fl);
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    int issues;
    vecs[0] = '{3'd0, 3'd0, 3'd1, 3'd2, 5'd0,  16'h0000, 32'h02324020};
    vecs[1] = '{3'd6, 3'd5, 3'd0, 3'd4, 5'd0,  16'h0005, 32'h221F0005};
    vecs[2] = '{3'd5, 3'd0, 3'd3, 3'd0, 5'd3,  16'h0000, 32'h001788C2};
    vecs[3] = '{3'd7, 3'd0, 3'd0, 3'd0, 5'd0,  16'h0000, 32'hFC000000};
    vecs[4] = '{3'd1, 3'd3, 3'd4, 3'd5, 5'd0,  16'h0000, 32'h02FF8024};
    vecs[5] = '{3'd3, 3'd6, 3'd7, 3'd1, 5'd0,  16'h0000, 32'h00009027};
    vecs[6] = '{3'd4, 3'd0, 3'd2, 3'd4, 5'd31, 16'h0000, 32'h0008FFC0};
    vecs[7] = '{3'd2, 3'd2, 3'd5, 3'd3, 5'd0,  16'h0000, 32'h0110B825};

    resetCycle();
    resetCycle();
    idleCycle();

    // Each vector alone: accept, issue one cycle later, then answer it.
    for (int i = 0; i < 8; i++) begin
      pushReq(vecs[i].op, vecs[i].rs, vecs[i].rt, vecs[i].rd, vecs[i].sh, vecs[i].imm);
      idleCycle();
      checkVal("tbl_in_valid", 32'(in_valid), 32'd1);
      checkVal("tbl_word", instruction, vecs[i].expWord);
      checkVal("tbl_outstanding", 32'(outstanding), 32'd1);
      respond(vecs[i].op == 3'd7);
      checkVal("tbl_out_after_resp", 32'(outstanding), 32'd0);
    end
    checkVal("tbl_fail_cnt", 32'(fail_cnt), 32'd1);

    // Two requests back to back leave in request order.
    pushReq(3'd6, 3'd5, 3'd0, 3'd4, 5'd0, 16'h0005);
    pushReq(3'd5, 3'd0, 3'd3, 3'd0, 5'd3, 16'h0000);
    checkVal("b2b_first", instruction, 32'h221F0005);
    idleCycle();
`ifndef MIPS_ISSUE_GAP_EN
    checkVal("b2b_second", instruction, 32'h001788C2);
`endif
    idleCycle();
    respond(1'b0);
    respond(1'b0);
    checkVal("b2b_drained", 32'(outstanding), 32'd0);

    // Fill: no responses, so only MAX_OUT issues happen and the FIFO fills.
    issues = 0;
    for (int i = 0; i < 8; i++) begin
      pushReq(3'd0, 3'd0, 3'd1, 3'd2, 5'd0, 16'd0);
      if (in_valid) issues++;
    end
    for (int i = 0; i < 4; i++) begin
      idleCycle();
      if (in_valid) issues++;
    end
    checkVal("fill_issues", 32'(issues), 32'd4);
    checkVal("fill_ready_low", 32'(req_ready), 32'd0);
    checkVal("fill_outstanding", 32'(outstanding), 32'd4);
    respond(1'b0);
    checkVal("release_wait", 32'(in_valid), 32'd0);
    idleCycle();
    checkVal("release_one", 32'(in_valid), 32'd1);
    idleCycle();
    checkVal("release_only_one", 32'(in_valid), 32'd0);

    // Reset with words queued and instructions outstanding.
    resetCycle();
    checkVal("rst_in_valid", 32'(in_valid), 32'd0);
    checkVal("rst_outstanding", 32'(outstanding), 32'd0);
    idleCycle();
    checkVal("rst_ready", 32'(req_ready), 32'd1);
    checkVal("rst_no_issue", 32'(in_valid), 32'd0);

    // A stray response after reset is sticky until the next reset.
    respond(1'b1);
    checkVal("unexp_err", 32'(err_unexpected), 32'd1);
    checkVal("unexp_outstanding", 32'(outstanding), 32'd0);
    idleCycle();
    idleCycle();
    checkVal("unexp_sticky", 32'(err_unexpected), 32'd1);
    resetCycle();
    checkVal("unexp_cleared", 32'(err_unexpected), 32'd0);

    // Randomized traffic against the model.
    for (int i = 0; i < 600; i++) begin
      bit rv, vv, ov, fv;
      rv = ($urandom_range(0, 99) == 0);
      vv = ($urandom_range(0, 2) != 0);
      ov = (mOut > 0) ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 29) == 0);
      fv = ($urandom_range(0, 3) == 0);
      applyStimulus(rv, vv, 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                    3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                    5'($urandom_range(0, 31)), 16'($urandom_range(0, 65535)), ov, fv);
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
